uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  UART transmit engine that sits directly downstream of uart_tx_clk_gen.
//  Accepts parallel words on a valid/ready handshake and shifts them out on tx,
//  LSB first: start bit, DATA_WIDTH data bits, optional parity, 1-2 stop bits.
//  Bit timing comes from rising edges of bit_clk, sampled in the sys_clk domain.
//  No second clock domain exists.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (5..9)
//  PARITY_EN   0  1 = append parity bit after the data bits
//  PARITY_ODD  0  0 = even parity (XOR of data); 1 = odd parity (~XOR of data)
//  STOP_BITS   1  number of stop bits (1 or 2)
// PORTS
//  sys_clk   in   1           system clock; all logic on its rising edge
//  reset_n   in   1           asynchronous, active-low reset
//  bit_clk   in   1           baud clock from uart_tx_clk_gen, synchronous to sys_clk
//  tx_data   in   DATA_WIDTH  word to send; sampled on accept
//  tx_valid  in   1           tx_data valid
//  tx_ready  out  1           block can accept a word this cycle
//  tx        out  1           serial line, idle high; registered
//  tx_busy   out  1           frame in progress or word pending
// BEHAVIOUR
//  - Reset (async, while reset_n=0):
//    - tx=1, tx_ready=1, tx_busy=0, state=IDLE, pending=0.
//    - bit_clk_d=1, so no spurious tick occurs on reset release.
//  - bit_tick = bit_clk & ~bit_clk_d, where bit_clk_d is bit_clk registered on sys_clk.
//    It is one sys_clk wide per bit period. All state/tx updates occur only at edges
//    where bit_tick=1, except handshake accept.
//  - States: IDLE, START, DATA, PARITY, STOP.
//    - Each non-IDLE state holds for exactly one bit period per bit (tick to tick).
//  - Accept = tx_valid & tx_ready.
//    - On accept: hold <= tx_data, pending <= 1.
//    - tx_ready falls the next cycle.
//    - tx_valid while tx_ready=0 is ignored; tx_data is not sampled.
//  - tx_ready = ~pending & (state==IDLE | (state==STOP & last stop bit)).
//  - tx_busy = pending | (state!=IDLE).
//  - Launch: on a tick in IDLE or in the last stop bit with pending=1:
//    - state<=START, tx<=0, shreg<=hold, pending<=0.
//    - Otherwise the last stop bit goes to IDLE (tx stays 1).
//  - START -> DATA on tick: tx<=shreg[0], shift right, bit_cnt<=0.
//  - DATA: on each tick bit_cnt++ and the next bit is driven.
//    - After bit DATA_WIDTH-1: go to PARITY if PARITY_EN, else STOP; tx<=1 in STOP.
//    - Parity is computed from the accepted word, not from the shifted remnant.
//  - STOP lasts STOP_BITS bit periods (stop counter).
//  - Latency: tx falls one sys_clk after the first bit_tick that follows the accept cycle.
//  - Accept in the same cycle as a tick: pending is not yet set, so the start bit
//    launches on the following tick (one bit period of idle).
//  - Back-to-back: a word accepted during the last stop bit starts on the tick that
//    ends that stop bit. No idle gap.
//  - Reset mid-frame: frame and pending word are discarded; tx returns high
//    immediately (async).
// TESTING (bench drives bit_clk with period 16 sys_clk, 50% duty; 8N1 unless noted)
//  1 Reset: reset_n=0 with bit_clk toggling -> tx=1, tx_ready=1, tx_busy=0.
//    Release -> no tx activity for 10 bit periods.
//  2 Single word 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
//    tx_ready low from accept+1 until the stop bit; tx_busy low after the stop bit.
//  3 Back-to-back 0x00 then 0xFF (second accepted during stop) -> 20 contiguous bits
//    0,00000000,1,0,11111111,1 with no extra idle.
//  4 PARITY_EN=1, data 0x07:
//    - PARITY_ODD=0 -> parity bit 1; PARITY_ODD=1 -> parity bit 0.
//    - STOP_BITS=2 -> 32 cycles high before the next start.
//  5 tx_valid held high with tx_data changing while busy -> only accepted words are sent.
//    Accept coincident with a bit_tick in IDLE -> start is delayed exactly one bit period.
//  6 reset_n pulsed low during data bit 3 of 0x3C -> tx=1 asynchronously.
//    After release, tx_ready=1; the next word 0x81 is framed correctly.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Purpose: UART transmit serializer; frames a word as start, data LSB first, optional parity, 1-2 stop bits.
// Latency: tx falls one sys_clk after the first bit_clk rising edge that follows the accept cycle.
// Backpressure: tx_ready is high only when no word is pending and the line is idle or in its last stop bit.
//
// Ports:
//   sys_clk  - system clock, all logic on its rising edge
//   reset_n  - asynchronous active-low reset
//   bit_clk  - baud clock, synchronous to sys_clk; its rising edge marks a bit boundary
//   tx_data  - word to send, captured on accept
//   tx_valid - tx_data valid
//   tx_ready - a word can be accepted this cycle
//   tx       - registered serial line, idle high
//   tx_busy  - frame in progress or word pending
`timescale 1ns/1ps
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   input  logic                  bit_clk,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx,
   output logic                  tx_busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t                  state_q, state_d;
   logic                    pending_q, pending_d;
   logic [DATA_WIDTH-1:0]   hold_q, hold_d;
   logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic                    stop_cnt_q, stop_cnt_d;
   logic                    parity_q, parity_d;
   logic                    tx_q, tx_d;
   logic                    bit_clk_q;

   logic bit_tick;
   logic last_stop;
   logic accept;

   // bit_clk_q resets high so a bit_clk already high at reset release
   // does not look like a fresh rising edge.
   assign bit_tick  = bit_clk & ~bit_clk_q;
   assign last_stop = (state_q == ST_STOP) && (stop_cnt_q == LAST_STOP);
   assign tx_ready  = ~pending_q & ((state_q == ST_IDLE) | last_stop);
   assign accept    = tx_valid & tx_ready;
   assign tx_busy   = pending_q | (state_q != ST_IDLE);
   assign tx        = tx_q;

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      hold_d     = hold_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      parity_d   = parity_q;
      tx_d       = tx_q;

      // accept and launch are mutually exclusive: accept needs pending=0,
      // launch needs pending=1.
      if (accept) begin
         hold_d    = tx_data;
         pending_d = 1'b1;
      end

      if (bit_tick) begin
         case (state_q)
            ST_IDLE, ST_STOP: begin
               if (state_q == ST_STOP && !last_stop) begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end else if (pending_q) begin
                  state_d   = ST_START;
                  tx_d      = 1'b0;
                  shreg_d   = hold_q;
                  pending_d = 1'b0;
                  // Parity latched from the full word; shreg is consumed by shifting.
                  parity_d  = (^hold_q) ^ (PARITY_ODD != 0);
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end
            ST_START: begin
               state_d   = ST_DATA;
               tx_d      = shreg_q[0];
               shreg_d   = shreg_q >> 1;
               bit_cnt_d = '0;
            end
            ST_DATA: begin
               if (bit_cnt_q == LAST_BIT) begin
                  if (PARITY_EN != 0) begin
                     state_d = ST_PARITY;
                     tx_d    = parity_q;
                  end else begin
                     state_d    = ST_STOP;
                     tx_d       = 1'b1;
                     stop_cnt_d = 1'b0;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  tx_d      = shreg_q[0];
                  shreg_d   = shreg_q >> 1;
               end
            end
            ST_PARITY: begin
               state_d    = ST_STOP;
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         pending_q  <= 1'b0;
         hold_q     <= '0;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
         bit_clk_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         hold_q     <= hold_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
         bit_clk_q  <= bit_clk;
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (8N1, 8E2, 8O1) on shared clocks.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

   logic       sys_clk;
   logic       bit_clk;
   logic       reset_n;
   logic [7:0] dat [3];
   logic [2:0] vld;
   logic [2:0] rdy;
   logic [2:0] tx_line;
   logic [2:0] busy;

   int checks = 0;
   int errors = 0;

   // unit 0: 8N1
   uart_tx_serializer #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .bit_clk(bit_clk),
      .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
      .tx(tx_line[0]), .tx_busy(busy[0]));

   // unit 1: 8E2
   uart_tx_serializer #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_even (
      .sys_clk(sys_clk), .reset_n(reset_n), .bit_clk(bit_clk),
      .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
      .tx(tx_line[1]), .tx_busy(busy[1]));

   // unit 2: 8O1
   uart_tx_serializer #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
      .sys_clk(sys_clk), .reset_n(reset_n), .bit_clk(bit_clk),
      .tx_data(dat[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
      .tx(tx_line[2]), .tx_busy(busy[2]));

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // 16 sys_clk period, edges land on sys_clk falling edges
   initial begin
      bit_clk = 1'b0;
      forever #80 bit_clk = ~bit_clk;
   end

   task automatic send(input int u, input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      @(negedge sys_clk);
      dat[u] = d;
      vld[u] = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         if (rdy[u]) begin
            ok = 1'b1;
            break;
         end
         @(negedge sys_clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_u%0d: tx_ready=%b, required 1 within budget", u, rdy[u]);
      end
      @(posedge sys_clk);
      @(negedge sys_clk);
      vld[u] = 1'b0;
   endtask

   task automatic wait_idle(input int u);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge sys_clk);
         if (!busy[u]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL idle_u%0d: tx_busy=%b, required 0 within budget", u, busy[u]);
      end
   endtask

   // Waits for the start bit, then checks every sys_clk sample of nbits bits.
   task automatic capture(input int u, input int nbits, input logic [31:0] exp_bits,
                          input string name, output logic [31:0] rdy_tr);
      bit found;
      int bad;
      found  = 1'b0;
      rdy_tr = '0;
      for (int n = 0; n < 4000; n++) begin
         @(negedge sys_clk);
         if (tx_line[u] == 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL %s start: tx=%b, required fall to 0 within budget", name, tx_line[u]);
         return;
      end
      for (int i = 0; i < nbits; i++) begin
         bad = 0;
         for (int j = 0; j < 16; j++) begin
            if (i != 0 || j != 0) @(negedge sys_clk);
            if (j == 8) rdy_tr[i] = rdy[u];
            if (tx_line[u] !== exp_bits[i]) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL %s bit%0d: %0d of 16 samples differ, required tx=%b", name, i, bad, exp_bits[i]);
         end
      end
   endtask

   task automatic test_reset();
      int bad;
      reset_n = 1'b0;
      repeat (40) @(negedge sys_clk);
      #1;
      checks++; if (tx_line[0] !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx_line[0]); end
      checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", rdy[0]); end
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy[0]); end
      wait (bit_clk == 1'b1);
      @(negedge sys_clk);
      #2 reset_n = 1'b1;
      bad = 0;
      repeat (160) begin
         @(negedge sys_clk);
         if (tx_line !== 3'b111 || busy !== 3'b000) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL reset_release_quiet: %0d active samples, required 0", bad); end
   endtask

   task automatic test_single();
      logic [31:0] tr;
      fork
         capture(0, 10, 32'b1101001010, "single_a5", tr);
         begin
            send(0, 8'hA5);
            checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL single_ready_after_accept: got %b required 0", rdy[0]); end
            checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_after_accept: got %b required 1", busy[0]); end
         end
      join
      checks++;
      if (tr[9:0] !== 10'b1000000000) begin
         errors++; $display("FAIL single_ready_trace: got %b required 1000000000", tr[9:0]);
      end
      @(negedge sys_clk);
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_after_stop: got %b required 0", busy[0]); end
      checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL single_ready_after_stop: got %b required 1", rdy[0]); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] tr;
      fork
         capture(0, 20, 32'b11111111101000000000, "b2b_00_ff", tr);
         begin
            send(0, 8'h00);
            send(0, 8'hFF);
         end
      join
      wait_idle(0);
   endtask

   task automatic test_parity();
      logic [31:0] tr;
      fork
         capture(1, 13, 32'b0111000001110, "even_2stop_07", tr);
         begin
            send(1, 8'h07);
            send(1, 8'h07);
         end
      join
      wait_idle(1);
      fork
         capture(2, 11, 32'b10000001110, "odd_07", tr);
         send(2, 8'h07);
      join
      wait_idle(2);
   endtask

   task automatic test_held_valid();
      logic [31:0] tr;
      int k;
      fork
         capture(0, 20, 32'b11001011001000100010, "held_valid_11_96", tr);
         begin
            k = 0;
            @(negedge sys_clk);
            vld[0] = 1'b1;
            for (int n = 0; n < 4000; n++) begin
               if (k == 2) break;
               if (rdy[0]) begin
                  dat[0] = (k == 0) ? 8'h11 : 8'h96;
                  k++;
               end else begin
                  dat[0] = 8'($urandom);
               end
               @(negedge sys_clk);
            end
            vld[0] = 1'b0;
            if (k != 2) begin
               checks++; errors++;
               $display("FAIL held_valid_accepts: got %0d words required 2", k);
            end
         end
      join
      wait_idle(0);
   endtask

   task automatic test_latency();
      int offs [2] = '{0, 3};
      int want [2] = '{17, 14};
      int lat;
      for (int t = 0; t < 2; t++) begin
         @(posedge bit_clk);
         repeat (offs[t]) @(negedge sys_clk);
         dat[0] = 8'h5A;
         vld[0] = 1'b1;
         @(negedge sys_clk);
         vld[0] = 1'b0;
         lat = 1;
         for (int n = 0; n < 100; n++) begin
            if (tx_line[0] == 1'b0) break;
            @(negedge sys_clk);
            lat++;
         end
         checks++;
         if (lat != want[t]) begin
            errors++; $display("FAIL latency_off%0d: got %0d cycles required %0d", offs[t], lat, want[t]);
         end
         wait_idle(0);
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] tr;
      bit found;
      found = 1'b0;
      send(0, 8'h3C);
      for (int n = 0; n < 4000; n++) begin
         @(negedge sys_clk);
         if (tx_line[0] == 1'b0) begin found = 1'b1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL midreset_start: tx=%b required fall to 0", tx_line[0]); end
      repeat (70) @(negedge sys_clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (tx_line[0] !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b required 1", tx_line[0]); end
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy[0]); end
      repeat (3) @(negedge sys_clk);
      #2 reset_n = 1'b1;
      @(negedge sys_clk);
      checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b required 1", rdy[0]); end
      fork
         capture(0, 10, 32'b1100000010, "after_reset_81", tr);
         send(0, 8'h81);
      join
      wait_idle(0);
   endtask

   initial begin
      reset_n = 1'b0;
      vld     = 3'b000;
      for (int i = 0; i < 3; i++) dat[i] = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_held_valid();
      test_latency();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
